// File: rtl/instr_encoder_loader_if.sv
// Request and memory-write bundle for instr_encoder_loader.
// master: boot sequencer side (drives requests, observes the write port).
// slave : loader side (accepts requests, drives imem_we/imem_addr/imem_wdata).
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_func3;
  logic              in_func7_5;
  logic [12:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_func3, in_func7_5,
           in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_func3, in_func7_5,
           in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Purpose : encodes field-level requests (LW/SW/R/I/BRANCH) into RV32I words
//           and writes them sequentially into instruction memory from word 0.
// Latency : request accepted on edge N -> imem_we pulse with registered
//           imem_addr/imem_wdata during the following cycle.
// Backpressure: in_ready is high only in LOAD; drops on the accepting edge of
//           an in_last request (DONE) or of the write to the top word (FULL).
// Ports   : clk, rst (async, active-high), start (session pulse),
//           bus (slave modport: in_* request handshake, imem_* write port),
//           word_count, done, overflow, err (sticky illegal-request flag).
// Option  : IMM_RANGE_CHECK_EN - out-of-range immediates are rejected like an
//           illegal class instead of being truncated.
module instr_encoder_loader #(
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]       word_count,
  output logic                  done,
  output logic                  overflow,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_FULL} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        class_ok;
  logic        imm_ok;
  logic        legal;
  logic        write;
  logic        at_top;
  logic [31:0] enc_word;

  assign accept = bus.in_valid & bus.in_ready;
  assign legal  = class_ok & imm_ok;
  assign write  = accept & legal;
  // In LOAD the count never exceeds the top index, so all-ones in the low
  // bits means the next write lands on the last word of memory.
  assign at_top = &word_count[ADDR_W-1:0];

  // Field packing, the inverse of the core's opcode/func3/func7 decode.
  always_comb begin
    enc_word = '0;
    class_ok = 1'b1;
    imm_ok   = 1'b1;
    case (bus.in_class)
      3'd0: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3, bus.in_rd, 7'b0000011};
      3'd1: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_func3,
                        bus.in_imm[4:0], 7'b0100011};
      3'd2: enc_word = {1'b0, bus.in_func7_5, 5'b00000, bus.in_rs2, bus.in_rs1,
                        bus.in_func3, bus.in_rd, 7'b0110011};
      3'd3: begin
        enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_func3, bus.in_rd, 7'b0010011};
        // Shifts (func3 001/101) carry func7 in the upper immediate bits.
        if (bus.in_func3[1:0] == 2'b01) begin
          enc_word[31:25] = {1'b0, bus.in_func7_5, 5'b00000};
        end
      end
      3'd4: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                        bus.in_func3, bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
      default: class_ok = 1'b0;
    endcase

`ifdef IMM_RANGE_CHECK_EN
    case (bus.in_class)
      3'd0, 3'd1: imm_ok = (bus.in_imm[12] == bus.in_imm[11]);
      3'd3: begin
        if (bus.in_func3[1:0] == 2'b01) begin
          imm_ok = (bus.in_imm[11:5] == 7'd0) && (bus.in_imm[12] == bus.in_imm[11]);
        end else begin
          imm_ok = (bus.in_imm[12] == bus.in_imm[11]);
        end
      end
      3'd4: imm_ok = ~bus.in_imm[0];
      default: imm_ok = 1'b1;
    endcase
`else
    // Out-of-range immediate bits are simply truncated by the packing above.
    imm_ok = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. start is ignored while a session is loading.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_FULL: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (accept && bus.in_last) begin
          state_nxt = S_DONE;
        end else if (write && at_top) begin
          state_nxt = S_FULL;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.in_ready = (state == S_LOAD);
    done         = (state == S_DONE);
    overflow     = (state == S_FULL);
  end

  // Write port, fill counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      word_count     <= '0;
      err            <= 1'b0;
    end else begin
      bus.imem_we <= write;
      if (write) begin
        bus.imem_addr  <= word_count[ADDR_W-1:0];
        bus.imem_wdata <= enc_word;
        word_count     <= word_count + 1'b1;
      end
      if (accept && !legal) begin
        err <= 1'b1;
      end
      if (start && state != S_LOAD) begin
        word_count <= '0;
        err        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (small memory, ADDR_W=2).
// The driver pushes expected writes into a scoreboard queue; a monitor pops
// and compares address, data and write cycle on every imem_we.
module tb_instr_encoder_loader;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   word_count;
  logic          done;
  logic          overflow;
  logic          err;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .word_count (word_count),
    .done       (done),
    .overflow   (overflow),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (bus.imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        check("wr_data", bus.imem_wdata, e.data);
        check("wr_cycle", cyc, e.at);
      end
    end
  end

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_class   = 3'd0;
    bus.in_rd      = 5'd0;
    bus.in_rs1     = 5'd0;
    bus.in_rs2     = 5'd0;
    bus.in_func3   = 3'd0;
    bus.in_func7_5 = 1'b0;
    bus.in_imm     = 13'd0;
    bus.in_last    = 1'b0;
  endtask

  // Called and returns at posedge+1.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request; if do_wr, expect 'word' at 'addr' one cycle later.
  task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic f75,
                      input logic [12:0] imm, input logic last, input logic do_wr,
                      input logic [31:0] word, input logic [AW-1:0] addr);
    int n;
    bus.in_class   = cls;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_func3   = f3;
    bus.in_func7_5 = f75;
    bus.in_imm     = imm;
    bus.in_last    = last;
    bus.in_valid   = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: got in_ready=0 for 20 cycles, required 1");
      idle_inputs();
      return;
    end
    @(posedge clk); #1;
    if (do_wr) sb.push_back('{addr, word, cyc});
    idle_inputs();
  endtask

  int ready_seen;
  logic exp_wr_i, exp_wr_b;
  logic [AW-1:0] a_srai, a_r;
  logic [AW:0]   wc_exp;

  initial begin
    idle_inputs();
    wait_cycles(2);
    // Reset state.
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_imem_we", 32'(bus.imem_we), 0);
    check("rst_imem_addr", 32'(bus.imem_addr), 0);
    check("rst_imem_wdata", bus.imem_wdata, 0);
    check("rst_word_count", 32'(word_count), 0);
    check("rst_flags", {29'd0, done, overflow, err}, 0);
    rst = 1'b0;
    wait_cycles(1);

    // Encode check: LW, ADD, SUB back to back.
    pulse_start();
    check("load_in_ready", 32'(bus.in_ready), 1);
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 13'd8, 1'b0, 1'b1, 32'h00812283, 2'd0);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 13'd0, 1'b0, 1'b1, 32'h002081B3, 2'd1);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 13'd0, 1'b1, 1'b1, 32'h402081B3, 2'd2);
    wait_cycles(1);
    check("enc_done", 32'(done), 1);
    check("enc_word_count", 32'(word_count), 3);

    // Store and branch.
    pulse_start();
    check("restart_done_clear", 32'(done), 0);
    send(3'd1, 5'd0, 5'd2, 5'd5, 3'b010, 1'b0, 13'd12, 1'b0, 1'b1, 32'h00512623, 2'd0);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 13'h1FFC, 1'b1, 1'b1, 32'hFE208EE3, 2'd1);
    wait_cycles(1);
    check("sb_done", 32'(done), 1);
    check("sb_word_count", 32'(word_count), 2);
    check("sb_in_ready", 32'(bus.in_ready), 0);
    check("sb_err", 32'(err), 0);

    // Illegal class between two legal requests.
    pulse_start();
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 13'd8, 1'b0, 1'b1, 32'h00812283, 2'd0);
    send(3'd6, 5'd7, 5'd7, 5'd7, 3'b111, 1'b1, 13'h0FF, 1'b0, 1'b0, 32'h0, 2'd0);
    check("ill_err_set", 32'(err), 1);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 13'd0, 1'b1, 1'b1, 32'h002081B3, 2'd1);
    wait_cycles(1);
    check("ill_word_count", 32'(word_count), 2);
    check("ill_done", 32'(done), 1);
    pulse_start();
    check("ill_err_cleared", 32'(err), 0);

    // Fill to overflow: four writes, fifth request must never be accepted.
    for (int i = 0; i < 4; i++) begin
      send(3'd3, 5'(i + 1), 5'd0, 5'd0, 3'b000, 1'b0, 13'(i), 1'b0, 1'b1,
           32'h00000013 | (32'(i) << 20) | (32'(i + 1) << 7), 2'(i));
    end
    check("full_overflow", 32'(overflow), 1);
    check("full_in_ready", 32'(bus.in_ready), 0);
    check("full_word_count", 32'(word_count), 4);
    bus.in_class = 3'd3;
    bus.in_valid = 1'b1;
    ready_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ready_seen++;
    end
    idle_inputs();
    check("full_fifth_refused", 32'(ready_seen), 0);
    wait_cycles(1);

    // Reset between acceptance and write cycle drops the write.
    pulse_start();
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 13'd0, 1'b0, 1'b0, 32'h0, 2'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(bus.imem_we), 0);
    check("mid_rst_wdata", bus.imem_wdata, 0);
    check("mid_rst_addr_count", {28'd0, word_count, 1'b0} | 32'(bus.imem_addr), 0);
    check("mid_rst_flags", {28'd0, bus.in_ready, done, overflow, err}, 0);
    @(negedge clk);
    check("mid_rst_we_negedge", 32'(bus.imem_we), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_idle_ready", 32'(bus.in_ready), 0);
    pulse_start();
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 13'd8, 1'b1, 1'b1, 32'h00812283, 2'd0);
    wait_cycles(1);

    // Immediate range handling.
`ifdef IMM_RANGE_CHECK_EN
    exp_wr_i = 1'b0; exp_wr_b = 1'b0; a_srai = 2'd0; a_r = 2'd1; wc_exp = 3'd2;
`else
    exp_wr_i = 1'b1; exp_wr_b = 1'b1; a_srai = 2'd2; a_r = 2'd3; wc_exp = 3'd4;
`endif
    pulse_start();
    send(3'd3, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 13'h0800, 1'b0, exp_wr_i, 32'h80000013, 2'd0);
    check("imm_i_err", 32'(err), exp_wr_i ? 0 : 1);
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 13'd3, 1'b0, exp_wr_b, 32'h00000163, 2'd1);
    send(3'd3, 5'd1, 5'd0, 5'd0, 3'b101, 1'b1, 13'd5, 1'b0, 1'b1, 32'h40505093, a_srai);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b0, 13'd0, 1'b1, 1'b1, 32'h002081B3, a_r);
    wait_cycles(1);
    check("imm_word_count", 32'(word_count), 32'(wc_exp));
    check("imm_done", 32'(done), 1);

    wait_cycles(3);
    check("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish by 100000, required finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential program loader that encodes field-level instruction requests into 32-bit RV32I words and writes them into instruction memory.
- Performs the inverse of the core's opcode/func3/func7 decode for the supported subset: LW, SW, R-type, I-type ALU, branch.
- Sits between a testbench/boot sequencer and the instruction memory write port.
- Takes requests over a valid/ready handshake, writes one word per accepted request, and tracks fill state.

Parameters:
- ADDR_W, 6, word-address width; memory depth = 2**ADDR_W words.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a load session at word 0.
- in_valid  input  1  request valid.
- in_ready  output  1  request can be accepted.
- in_class  input  3  0=LW, 1=SW, 2=R, 3=I, 4=BRANCH, 5..7 illegal.
- in_rd  input  5  destination register.
- in_rs1  input  5  source 1.
- in_rs2  input  5  source 2.
- in_func3  input  3  func3 field.
- in_func7_5  input  1  func7 bit 5 (sub/sra select).
- in_imm  input  13  signed immediate; bits [11:0] used for I/S, [12:1] for B.
- in_last  input  1  marks final request of the program.
- imem_we  output  1  memory write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded word.
- word_count  output  ADDR_W+1  words written this session.
- done  output  1  high in DONE state.
- overflow  output  1  high in FULL state.
- err  output  1  sticky; an illegal class was seen this session.

Behaviour:
- Reset: state IDLE; in_ready, imem_we, done, overflow, err = 0; imem_addr, imem_wdata, word_count = 0.
- Reset mid-session: any pending write is dropped and the block returns to IDLE.
- States:
  - IDLE: start -> LOAD, with addr=0, word_count=0, err=0.
  - LOAD: in_ready=1. On the cycle an accepted request with in_last writes (or is dropped), go to DONE. On the cycle the word at addr 2**ADDR_W-1 is written without in_last, go to FULL.
  - DONE and FULL: in_ready=0. start restarts the session as from IDLE.
  - start received while in LOAD is ignored.
- Handshake: transfer occurs when in_valid & in_ready. Back-to-back transfers are allowed, one per cycle.
- Latency: request accepted at cycle N -> imem_we=1 at cycle N+1 with registered imem_addr/imem_wdata. imem_we is a one-cycle pulse per legal request.
- Address and count: addr increments after each write and never wraps. word_count increments with each write.
- Encoding, msb->lsb:
  - LW: imm[11:0], rs1, func3, rd, 0000011.
  - SW: imm[11:5], rs2, rs1, func3, imm[4:0], 0100011.
  - R: 0, func7_5, 00000, rs2, rs1, func3, rd, 0110011.
  - I: imm[11:0], rs1, func3, rd, 0010011. For func3 001/101, bits [31:25] are replaced by {0, func7_5, 00000}.
  - BRANCH: imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], 1100011.
- Illegal class: the handshake completes, no write occurs, addr and count are unchanged, and err is set. in_last is still honoured (-> DONE).
- done, overflow, and err hold until the next start or reset.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: the request is treated exactly as an illegal class (no write, err set) if any of these hold:
  - LW/SW/I: in_imm[12] != in_imm[11], i.e. outside the 12-bit signed range.
  - BRANCH: in_imm[0] = 1.
  - I with func3 001/101: in_imm[11:5] != 0.
- Undefined: out-of-range bits are truncated silently and the word is written.

Test Plan:
- Encode check: start, then send LW rd=5 rs1=2 f3=010 imm=8, then R rd=3 rs1=1 rs2=2 f3=000 f7_5=0, then the same with f7_5=1. Required: writes at addr 0,1,2 of 0x00812283, 0x002081B3, 0x402081B3, each one cycle after acceptance.
- Store and branch: SW rs2=5 rs1=2 f3=010 imm=12 -> 0x00512623. BEQ rs1=1 rs2=2 imm=-4 (0x1FFC) with in_last -> 0xFE208EE3. Then done=1, word_count=2, in_ready=0.
- Illegal class: send class=6 between two legal requests. Required: no imem_we for it, the second legal word lands at addr 1, err=1.
- Fill to overflow: ADDR_W=2, five requests without in_last. Required: four writes at addr 0..3, then overflow=1 and in_ready=0; the fifth request is never accepted.
- Reset mid-session: assert rst on the cycle after acceptance, before the write cycle. Required: no imem_we, all outputs 0, state IDLE. A subsequent start gives addr=0.
- With IMM_RANGE_CHECK_EN defined: I-type imm=0x0800 -> no write, err=1. BRANCH imm=3 -> no write. Without the macro, the same I-type request writes 0x80000013-pattern bits (truncated imm).
